// File: rtl/wb_copy_master_if.sv
// Wishbone pipelined bus bundle between the block-copy master and the slave fabric.
// Signal suffixes are named from the master's point of view.
interface wb_copy_master_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   wb_addr_o;
  logic [DW-1:0]   wb_dat_o;
  logic [DW/8-1:0] wb_sel_o;
  logic            wb_cyc_o;
  logic            wb_stb_o;
  logic            wb_we_o;
  logic [DW-1:0]   wb_dat_i;
  logic            wb_stall_i;
  logic            wb_ack_i;
  logic            wb_err_i;

  modport master (
    output wb_addr_o, wb_dat_o, wb_sel_o, wb_cyc_o, wb_stb_o, wb_we_o,
    input  wb_dat_i, wb_stall_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_addr_o, wb_dat_o, wb_sel_o, wb_cyc_o, wb_stb_o, wb_we_o,
    output wb_dat_i, wb_stall_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/wb_copy_master.sv
// Wishbone pipelined master that copies a block of 32-bit words, one word in
// flight (read, write, advance), aborting on bus error or watchdog expiry.
module wb_copy_master #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AW-1:0]        src_addr_i,
  input  logic [AW-1:0]        dst_addr_i,
  input  logic [LW-1:0]        len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [LW-1:0]        words_done_o,
  wb_copy_master_if.master     wb
);

  localparam int              WDW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0]  WD_LAST   = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;
  localparam logic [AW-1:0]   ADDR_MASK = {{(AW-2){1'b1}}, 2'b00};
  localparam logic [AW-1:0]   ADDR_STEP = AW'(4);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_WAIT = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   src_q, src_d;
  logic [AW-1:0]   dst_q, dst_d;
  logic [LW-1:0]   len_q, len_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [WDW-1:0]  wdog_q, wdog_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            cyc_q, cyc_d;
  logic            stb_q, stb_d;
  logic            we_q, we_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [DW/8-1:0] sel_q, sel_d;
  logic            abort_s;
  logic            wd_expired_s;
  logic [LW-1:0]   cnt_inc_s;

  // Next-state, datapath and registered-output next values
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    dat_d        = dat_q;
    wdog_d       = '0;
    cnt_d        = cnt_q;
    err_d        = err_q;
    done_d       = 1'b0;
    abort_s      = 1'b0;
    cnt_inc_s    = cnt_q + LW'(1);
    wd_expired_s = (TIMEOUT != 0) && (wdog_q == WD_LAST);

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          src_d = src_addr_i & ADDR_MASK;
          dst_d = dst_addr_i & ADDR_MASK;
          len_d = len_i;
          err_d = 1'b0;
          cnt_d = '0;
          if (len_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RD_REQ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_REQ: begin
        if (!wb.wb_stall_i) begin
          state_d = S_RD_WAIT;
        end else begin
          state_d = S_RD_REQ;
        end
      end
      S_RD_WAIT: begin
        // err wins over a simultaneous ack
        if (wb.wb_err_i) begin
          abort_s = 1'b1;
        end else if (wb.wb_ack_i) begin
          dat_d   = wb.wb_dat_i;
          state_d = S_WR_REQ;
        end else if (wd_expired_s) begin
          abort_s = 1'b1;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end
      S_WR_REQ: begin
        if (!wb.wb_stall_i) begin
          state_d = S_WR_WAIT;
        end else begin
          state_d = S_WR_REQ;
        end
      end
      S_WR_WAIT: begin
        if (wb.wb_err_i) begin
          abort_s = 1'b1;
        end else if (wb.wb_ack_i) begin
          cnt_d = cnt_inc_s;
          src_d = src_q + ADDR_STEP;
          dst_d = dst_q + ADDR_STEP;
          if (cnt_inc_s == len_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RD_REQ;
          end
        end else if (wd_expired_s) begin
          abort_s = 1'b1;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort_s) begin
      err_d   = 1'b1;
      done_d  = 1'b1;
      state_d = S_IDLE;
    end else begin
      err_d = err_d;
    end

    // Bus outputs are derived from the next state so they leave the flops clean
    busy_d = (state_d != S_IDLE);
    cyc_d  = busy_d;
    stb_d  = (state_d == S_RD_REQ) || (state_d == S_WR_REQ);
    we_d   = (state_d == S_WR_REQ) || (state_d == S_WR_WAIT);
    sel_d  = busy_d ? '1 : '0;
    case (state_d)
      S_RD_REQ, S_RD_WAIT: adr_d = src_d;
      S_WR_REQ, S_WR_WAIT: adr_d = dst_d;
      default:             adr_d = '0;
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      dat_q   <= '0;
      wdog_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      dat_q   <= dat_d;
      wdog_q  <= wdog_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign words_done_o = cnt_q;
  assign wb.wb_addr_o = adr_q;
  assign wb.wb_dat_o  = dat_q;
  assign wb.wb_sel_o  = sel_q;
  assign wb.wb_cyc_o  = cyc_q;
  assign wb.wb_stb_o  = stb_q;
  assign wb.wb_we_o   = we_q;

endmodule

// File: tb/tb_wb_copy_master.sv
// Self-checking bench for wb_copy_master: behavioural Wishbone slave with ROM/RAM
// maps, directed and randomized copies checked against the expected memory image.
module tb_wb_copy_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 16;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_a = 32'h0;
  logic [31:0] dst_a = 32'h0;
  logic [15:0] len = 16'h0;
  logic        busy, done, err;
  logic [15:0] wdone;

  wb_copy_master_if #(.AW(AW), .DW(DW)) bus ();

  wb_copy_master #(.AW(AW), .DW(DW), .LW(LW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .src_addr_i(src_a), .dst_addr_i(dst_a), .len_i(len),
    .busy_o(busy), .done_o(done), .err_o(err), .words_done_o(wdone),
    .wb(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int start_cyc = 0;

  // slave configuration (written by the stimulus) and bookkeeping (written by the slave)
  logic [31:0] rom [logic [31:0]];
  logic [31:0] ram [logic [31:0]];
  int stall_n = 0, ack_dly = 0, err_at_wr = -1;
  bit no_ack = 1'b0;
  int n_rd = 0, n_wr = 0, hold_viol = 0;
  bit acc_pend = 1'b0, acc_we = 1'b0, resp_act = 1'b0, resp_err = 1'b0, stalled_prev = 1'b0, stall_we = 1'b0;
  logic [31:0] acc_adr = 32'h0, acc_dat = 32'h0, resp_dat = 32'h0, stall_adr = 32'h0;
  int resp_cnt = 0, stall_cnt = 0;

  // monitor
  int done_cnt = 0, done_cyc = 0, cyc_rises = 0, cyc_rise_cyc = 0;
  logic busy_at_done = 1'b0, cyc_at_done = 1'b0, cyc_prev = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cycle;
      busy_at_done = busy;
      cyc_at_done = bus.wb_cyc_o;
    end
    if (bus.wb_cyc_o === 1'b1 && cyc_prev !== 1'b1) begin
      cyc_rises++;
      cyc_rise_cyc = cycle;
    end
    cyc_prev = bus.wb_cyc_o;
  end

  // Behavioural pipelined slave: drives stall/ack/err/dat on the falling edge
  always @(negedge clk) begin
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    if (rst) begin
      acc_pend = 1'b0; resp_act = 1'b0; stall_cnt = 0; stalled_prev = 1'b0;
      bus.wb_stall_i = 1'b0;
      bus.wb_dat_i = 32'h0;
    end else begin
      if (acc_pend) begin
        acc_pend = 1'b0;
        if (acc_we) begin
          n_wr++;
          resp_dat = 32'h0;
          if (n_wr == err_at_wr) resp_err = 1'b1;
          else begin resp_err = 1'b0; ram[acc_adr] = acc_dat; end
        end else begin
          n_rd++;
          resp_err = 1'b0;
          resp_dat = rom.exists(acc_adr) ? rom[acc_adr] : ~acc_adr;
        end
        resp_act = 1'b1; resp_cnt = ack_dly; stall_cnt = 0;
      end
      if (resp_act && !no_ack) begin
        if (resp_cnt == 0) begin
          resp_act = 1'b0;
          if (resp_err) bus.wb_err_i = 1'b1; else bus.wb_ack_i = 1'b1;
          bus.wb_dat_i = resp_dat;
        end else resp_cnt--;
      end
      if (stalled_prev) begin
        if (!(bus.wb_stb_o === 1'b1 && bus.wb_addr_o === stall_adr && bus.wb_we_o === stall_we)) hold_viol++;
      end
      if (bus.wb_cyc_o === 1'b1 && bus.wb_stb_o === 1'b1 && stall_cnt < stall_n) begin
        bus.wb_stall_i = 1'b1; stall_cnt++; stalled_prev = 1'b1;
        stall_adr = bus.wb_addr_o; stall_we = bus.wb_we_o;
      end else begin
        bus.wb_stall_i = 1'b0; stalled_prev = 1'b0;
      end
      if (bus.wb_cyc_o === 1'b1 && bus.wb_stb_o === 1'b1 && !bus.wb_stall_i) begin
        acc_pend = 1'b1; acc_adr = bus.wb_addr_o; acc_we = bus.wb_we_o; acc_dat = bus.wb_dat_o;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    tick(1);
    src_a = s; dst_a = d; len = l; start = 1'b1; start_cyc = cycle;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, output bit ok);
    int n;
    n = 0;
    while (done_cnt == base && n < budget) begin tick(1); n++; end
    ok = (done_cnt != base);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  // Full copy with a well-behaved slave; expected image derived from the ROM contents
  task automatic run_copy(input string tag, input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] l, input int stl, input int dly, input bit mid);
    int b_done, b_rd, b_wr, b_rise, b_hold;
    bit ok;
    logic [31:0] sa, da, ea;
    stall_n = stl; ack_dly = dly;
    sa = s & 32'hFFFF_FFFC;
    da = d & 32'hFFFF_FFFC;
    for (int i = 0; i < int'(l); i++) begin
      ea = sa + 32'(4 * i);
      if (!rom.exists(ea)) rom[ea] = $urandom;
    end
    b_done = done_cnt; b_rd = n_rd; b_wr = n_wr; b_rise = cyc_rises; b_hold = hold_viol;
    launch(s, d, l);
    if (mid) begin
      tick(4);
      src_a = 32'h0000_9000; len = 16'd7; start = 1'b1;
      tick(1);
      start = 1'b0;
    end
    wait_done(b_done, 600, ok);
    tick(3);
    check({tag, "_finished"}, 64'(ok), 64'd1);
    check({tag, "_done_once"}, 64'(done_cnt - b_done), 64'd1);
    check({tag, "_latency"}, 64'(done_cyc - start_cyc), 64'(int'(l) * (4 + 2 * stl + 2 * dly) + 1));
    check({tag, "_first_stb"}, 64'(cyc_rise_cyc - start_cyc), 64'd1);
    check({tag, "_cyc_continuous"}, 64'(cyc_rises - b_rise), 64'd1);
    check({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
    check({tag, "_words_done"}, 64'(wdone), 64'(l));
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_reads"}, 64'(n_rd - b_rd), 64'(l));
    check({tag, "_writes"}, 64'(n_wr - b_wr), 64'(l));
    check({tag, "_stall_hold"}, 64'(hold_viol - b_hold), 64'd0);
    for (int i = 0; i < int'(l); i++) begin
      check($sformatf("%s_ram[%0d]", tag, i), 64'(ram[da + 32'(4 * i)]), 64'(rom[sa + 32'(4 * i)]));
    end
  endtask

  initial begin
    int b_done, b_rd, b_wr, b_rise, n;
    bit ok, found;
    logic [31:0] rs, rd;

    tick(2);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_words", 64'(wdone), 64'd0);
    check("rst_cyc", 64'(bus.wb_cyc_o), 64'd0);
    check("rst_stb", 64'(bus.wb_stb_o), 64'd0);
    check("rst_we", 64'(bus.wb_we_o), 64'd0);
    check("rst_addr", 64'(bus.wb_addr_o), 64'd0);
    check("rst_sel", 64'(bus.wb_sel_o), 64'd0);
    check("rst_dat", 64'(bus.wb_dat_o), 64'd0);
    rst = 1'b0;
    tick(1);

    rom[32'h0] = 32'h11; rom[32'h4] = 32'h22; rom[32'h8] = 32'h33; rom[32'hC] = 32'h44;
    run_copy("basic", 32'h0000_0000, 32'h0010_0000, 16'd4, 0, 0, 1'b0);
    check("basic_ram_c", 64'(ram[32'h0010_000C]), 64'h44);

    run_copy("stall", 32'h0000_0200, 32'h0020_0200, 16'd2, 3, 0, 1'b0);

    // bus error on the second write ack
    stall_n = 0; ack_dly = 0;
    for (int i = 0; i < 5; i++) rom[32'h400 + 32'(4 * i)] = $urandom;
    b_done = done_cnt; b_rd = n_rd; b_wr = n_wr;
    err_at_wr = n_wr + 2;
    launch(32'h0000_0400, 32'h3000_0000, 16'd5);
    wait_done(b_done, 200, ok);
    tick(5);
    err_at_wr = -1;
    check("berr_finished", 64'(ok), 64'd1);
    check("berr_err", 64'(err), 64'd1);
    check("berr_words", 64'(wdone), 64'd1);
    check("berr_latency", 64'(done_cyc - start_cyc), 64'd9);
    check("berr_cyc_at_done", 64'(cyc_at_done), 64'd0);
    check("berr_done_once", 64'(done_cnt - b_done), 64'd1);
    check("berr_reads", 64'(n_rd - b_rd), 64'd2);
    check("berr_writes", 64'(n_wr - b_wr), 64'd2);
    check("berr_ram0", 64'(ram[32'h3000_0000]), 64'(rom[32'h400]));
    check("berr_ram1_absent", 64'(ram.exists(32'h3000_0004)), 64'd0);
    check("berr_busy", 64'(busy), 64'd0);

    // zero length: immediate done, no bus activity, clears the sticky error
    b_done = done_cnt; b_rd = n_rd; b_rise = cyc_rises;
    launch(32'h0000_0500, 32'h0040_0500, 16'd0);
    wait_done(b_done, 20, ok);
    tick(2);
    check("len0_finished", 64'(ok), 64'd1);
    check("len0_latency", 64'(done_cyc - start_cyc), 64'd1);
    check("len0_err_cleared", 64'(err), 64'd0);
    check("len0_words", 64'(wdone), 64'd0);
    check("len0_no_cyc", 64'(cyc_rises - b_rise), 64'd0);
    check("len0_no_reads", 64'(n_rd - b_rd), 64'd0);

    run_copy("midstart", 32'h0000_0600, 32'h0040_0600, 16'd3, 0, 1, 1'b1);
    run_copy("wrap", 32'h0000_0800, 32'hFFFF_FFFC, 16'd2, 0, 0, 1'b0);
    check("wrap_second_at_zero", 64'(ram[32'h0000_0000]), 64'(rom[32'h804]));

    // watchdog: first read never acknowledged
    b_done = done_cnt; b_rd = n_rd; b_wr = n_wr;
    no_ack = 1'b1;
    launch(32'h0000_0700, 32'h5000_0000, 16'd3);
    wait_done(b_done, 100, ok);
    tick(3);
    check("tmo_finished", 64'(ok), 64'd1);
    check("tmo_latency", 64'(done_cyc - start_cyc), 64'd10);
    check("tmo_err", 64'(err), 64'd1);
    check("tmo_busy", 64'(busy), 64'd0);
    check("tmo_words", 64'(wdone), 64'd0);
    check("tmo_reads", 64'(n_rd - b_rd), 64'd1);
    check("tmo_writes", 64'(n_wr - b_wr), 64'd0);
    check("tmo_done_once", 64'(done_cnt - b_done), 64'd1);
    no_ack = 1'b0;
    apply_reset();
    check("tmo_err_after_reset", 64'(err), 64'd0);

    // asynchronous reset while waiting on a write ack
    ack_dly = 3; stall_n = 0;
    b_done = done_cnt;
    launch(32'h0000_0A00, 32'h0050_0A00, 16'd3);
    found = 1'b0; n = 0;
    while (!found && n < 60) begin
      tick(1); n++;
      found = (bus.wb_cyc_o === 1'b1 && bus.wb_we_o === 1'b1 && bus.wb_stb_o === 1'b0);
    end
    check("arst_reached_wr_wait", 64'(found), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_cyc_async", 64'(bus.wb_cyc_o), 64'd0);
    check("arst_stb_async", 64'(bus.wb_stb_o), 64'd0);
    check("arst_busy_async", 64'(busy), 64'd0);
    tick(3);
    rst = 1'b0;
    tick(2);
    check("arst_no_done", 64'(done_cnt - b_done), 64'd0);
    check("arst_words", 64'(wdone), 64'd0);
    run_copy("post_rst", 32'h0000_0B00, 32'h0060_0B00, 16'd1, 0, 0, 1'b0);

    for (int k = 0; k < 4; k++) begin
      rs = 32'h1000_0000 + (32'($urandom_range(0, 255)) << 6) + 32'($urandom_range(0, 3));
      rd = 32'h2000_0000 + 32'(k * 256) + 32'($urandom_range(0, 3));
      run_copy($sformatf("rand%0d", k), rs, rd, 16'($urandom_range(1, 6)),
               int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: bench did not complete within its time limit");
    $fatal(1, "time limit");
  end
endmodule
